// File: rtl/io_mmio_ctrl.sv
// Memory-mapped IO controller: LED register, switch readback and keypad FIFO
// behind a 3-state CPU handshake. Define IO_BUSERR_EN to add bus-error reporting.
module io_mmio_ctrl #(
  parameter logic [31:0] BASE_ADDR  = 32'hFFFFFC00,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        lock_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        ready_o,
`ifdef IO_BUSERR_EN
  output logic        buserr_o,
  output logic [3:0]  exc_code_o,
`endif
  input  logic [23:0] switch_i,
  input  logic        key_valid_i,
  input  logic [3:0]  key_val_i,
  output logic [23:0] led_o
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [9:0] OFF_LED  = 10'h060;
  localparam logic [9:0] OFF_SW   = 10'h070;
  localparam logic [9:0] OFF_KDAT = 10'h080;
  localparam logic [9:0] OFF_KSTA = 10'h084;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [31:0]       addr_q, addr_d;
  logic              we_q, we_d;
  logic [23:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              ready_q, ready_d;
  logic [23:0]       led_q, led_d;

  logic [3:0]        fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;

  logic              in_win;
  logic [9:0]        offset;
  logic              full;
  logic              pop;
  logic              push;
  logic              drop;
  logic              stat_rd;
  logic              bad_acc;

`ifdef IO_BUSERR_EN
  logic              buserr_q, buserr_d;
  logic [3:0]        exc_q, exc_d;
`else
  logic              unused_bad;
  assign unused_bad = bad_acc;
`endif

  logic              unused_wdata;
  assign unused_wdata = ^wdata_i[31:24];

  // State and datapath registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      ready_q  <= 1'b0;
      led_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
`ifdef IO_BUSERR_EN
      buserr_q <= 1'b0;
      exc_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      ready_q  <= ready_d;
      led_q    <= led_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
`ifdef IO_BUSERR_EN
      buserr_q <= buserr_d;
      exc_q    <= exc_d;
`endif
    end
  end

  // Keypad storage needs no reset; pointers and count define validity
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= key_val_i;
    end
  end

  always_comb begin
    in_win   = (addr_q[31:10] == BASE_ADDR[31:10]);
    offset   = addr_q[9:0];
    full     = (count_q == CNT_W'(FIFO_DEPTH));

    state_d  = state_q;
    addr_d   = addr_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    ready_d  = 1'b0;
    led_d    = led_q;
    pop      = 1'b0;
    stat_rd  = 1'b0;
    bad_acc  = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_i && !lock_i) begin
          addr_d  = addr_i;
          we_d    = we_i;
          wdata_d = wdata_i[23:0];
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        state_d = RESP;
        ready_d = 1'b1;
        rdata_d = '0;
        if (!in_win) begin
          bad_acc = 1'b1;
        end else begin
          case (offset)
            OFF_LED: begin
              if (we_q) led_d   = wdata_q;
              else      rdata_d = {8'd0, led_q};
            end
            OFF_SW: begin
              if (we_q) bad_acc = 1'b1;
              else      rdata_d = {8'd0, switch_i};
            end
            OFF_KDAT: begin
              if (we_q) begin
                bad_acc = 1'b1;
              end else if (count_q != '0) begin
                rdata_d = {28'd0, fifo_q[rd_ptr_q]};
                pop     = 1'b1;
              end
            end
            OFF_KSTA: begin
              if (we_q) begin
                bad_acc = 1'b1;
              end else begin
                rdata_d = {26'd0, ovf_q, full, 4'(count_q)};
                stat_rd = 1'b1;
              end
            end
            default: bad_acc = 1'b1;
          endcase
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A pop in the same cycle frees a slot, so a full FIFO still accepts the push
    push     = key_valid_i && (!full || pop);
    drop     = key_valid_i && full && !pop;
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    // Status read clears overflow, but a key dropped in that same cycle re-sets it
    ovf_d    = stat_rd ? drop : (ovf_q | drop);

`ifdef IO_BUSERR_EN
    buserr_d = 1'b0;
    exc_d    = '0;
    if (state_q == ACCESS && bad_acc) begin
      buserr_d = 1'b1;
      exc_d    = we_q ? 4'd5 : 4'd4;
    end
`endif
  end

  assign rdata_o    = rdata_q;
  assign ready_o    = ready_q;
  assign led_o      = led_q;
`ifdef IO_BUSERR_EN
  assign buserr_o   = buserr_q;
  assign exc_code_o = exc_q;
`endif

endmodule

// File: tb/tb_io_mmio_ctrl.sv
// Self-checking bench for io_mmio_ctrl: vector table, directed corner cases
// and random traffic against a queue-based reference model.
module tb_io_mmio_ctrl;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] A_LED  = 32'hFFFFFC60;
  localparam logic [31:0] A_SW   = 32'hFFFFFC70;
  localparam logic [31:0] A_KDAT = 32'hFFFFFC80;
  localparam logic [31:0] A_KSTA = 32'hFFFFFC84;

  logic        clk = 1'b0;
  logic        reset, lock, req, we_r, key_valid;
  logic [31:0] addr_r, wdata_r, rdata;
  logic        ready;
  logic [23:0] sw, led;
  logic [3:0]  key_val;
`ifdef IO_BUSERR_EN
  logic        buserr;
  logic [3:0]  exc;
`endif

  int n_chk = 0;
  int n_fail = 0;

  // reference model state
  logic [23:0] led_m;
  int          q_m[$];
  bit          ovf_m;

  io_mmio_ctrl dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .lock_i      (lock),
    .req_i       (req),
    .we_i        (we_r),
    .addr_i      (addr_r),
    .wdata_i     (wdata_r),
    .rdata_o     (rdata),
    .ready_o     (ready),
`ifdef IO_BUSERR_EN
    .buserr_o    (buserr),
    .exc_code_o  (exc),
`endif
    .switch_i    (sw),
    .key_valid_i (key_valid),
    .key_val_i   (key_val),
    .led_o       (led)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [23:0] sw;
    bit          chk_rd;
    logic [31:0] exp_rd;
    logic [23:0] exp_led;
    bit          exp_err;
    logic [3:0]  exp_exc;
  } vec_t;

  vec_t vec [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One complete transaction; optionally strobes a key during the ACCESS edge
  task automatic do_access(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                           input bit inj, input logic [3:0] kv,
                           output logic [31:0] rd, output bit e, output logic [3:0] x);
    int lat;
    bit got;
    @(negedge clk);
    req = 1'b1; we_r = we; addr_r = addr; wdata_r = wd;
    lat = 0; got = 1'b0; rd = '0; e = 1'b0; x = '0;
    while (!got && lat < 8) begin
      @(posedge clk); #1;
      lat++;
      if (inj && lat == 1) begin
        key_valid = 1'b1; key_val = kv;
      end else begin
        key_valid = 1'b0;
      end
      if (ready) begin
        got = 1'b1;
        rd  = rdata;
`ifdef IO_BUSERR_EN
        e = buserr;
        x = exc;
`endif
      end
    end
    key_valid = 1'b0;
    req = 1'b0;
    chk("latency", 32'(lat), 32'd2);
    if (got) begin
      @(posedge clk); #1;
      chk("ready_pulse", 32'(ready), 32'd0);
    end
  endtask

  task automatic push_key(input logic [3:0] v);
    @(negedge clk);
    key_valid = 1'b1; key_val = v;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic read_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] rd;
    bit e;
    logic [3:0] x;
    do_access(1'b0, addr, 32'd0, 1'b0, 4'd0, rd, e, x);
    chk(name, rd, exp);
  endtask

  task automatic read_inj(input string name, input logic [31:0] addr, input logic [3:0] kv,
                          input logic [31:0] exp);
    logic [31:0] rd;
    bit e;
    logic [3:0] x;
    do_access(1'b0, addr, 32'd0, 1'b1, kv, rd, e, x);
    chk(name, rd, exp);
  endtask

  function automatic logic [31:0] stat_m();
    return {26'd0, ovf_m, (q_m.size() == DEPTH), 4'(q_m.size())};
  endfunction

  initial begin
    logic [31:0] rd, a, wd, ex;
    bit e, saw;
    logic [3:0] x, k;
    int n, op;

    reset = 1'b1; lock = 1'b0; req = 1'b0; we_r = 1'b0; addr_r = '0; wdata_r = '0;
    sw = '0; key_valid = 1'b0; key_val = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_led", 32'(led), 32'd0);
`ifdef IO_BUSERR_EN
    chk("rst_buserr", 32'(buserr), 32'd0);
    chk("rst_exc", 32'(exc), 32'd0);
`endif

    vec[0]  = '{1'b1, A_LED,         32'h00ABCDEF, 24'h0,      1'b0, 32'h0,        24'hABCDEF, 1'b0, 4'd0};
    vec[1]  = '{1'b0, A_LED,         32'h0,        24'h0,      1'b1, 32'h00ABCDEF, 24'hABCDEF, 1'b0, 4'd0};
    vec[2]  = '{1'b0, A_SW,          32'h0,        24'h123456, 1'b1, 32'h00123456, 24'hABCDEF, 1'b0, 4'd0};
    vec[3]  = '{1'b0, 32'hFFFFFC90,  32'h0,        24'h123456, 1'b1, 32'h0,        24'hABCDEF, 1'b1, 4'd4};
    vec[4]  = '{1'b1, A_SW,          32'hFFFFFFFF, 24'h0,      1'b0, 32'h0,        24'hABCDEF, 1'b1, 4'd5};
    vec[5]  = '{1'b1, 32'h00000060,  32'h00111111, 24'h0,      1'b0, 32'h0,        24'hABCDEF, 1'b1, 4'd5};
    vec[6]  = '{1'b0, 32'h00000060,  32'h0,        24'h0,      1'b1, 32'h0,        24'hABCDEF, 1'b1, 4'd4};
    vec[7]  = '{1'b1, A_LED,         32'hFF123456, 24'h0,      1'b0, 32'h0,        24'h123456, 1'b0, 4'd0};
    vec[8]  = '{1'b0, A_LED,         32'h0,        24'h0,      1'b1, 32'h00123456, 24'h123456, 1'b0, 4'd0};
    vec[9]  = '{1'b0, A_KDAT,        32'h0,        24'h0,      1'b1, 32'h0,        24'h123456, 1'b0, 4'd0};
    vec[10] = '{1'b0, A_KSTA,        32'h0,        24'h0,      1'b1, 32'h0,        24'h123456, 1'b0, 4'd0};
    vec[11] = '{1'b1, A_KSTA,        32'hFFFFFFFF, 24'h0,      1'b0, 32'h0,        24'h123456, 1'b1, 4'd5};
    vec[12] = '{1'b0, 32'hFFFFFC61,  32'h0,        24'h0,      1'b1, 32'h0,        24'h123456, 1'b1, 4'd4};

    foreach (vec[i]) begin
      sw = vec[i].sw;
      do_access(vec[i].we, vec[i].addr, vec[i].wdata, 1'b0, 4'd0, rd, e, x);
      if (vec[i].chk_rd) chk($sformatf("vec%0d_rdata", i), rd, vec[i].exp_rd);
      chk($sformatf("vec%0d_led", i), 32'(led), 32'(vec[i].exp_led));
`ifdef IO_BUSERR_EN
      chk($sformatf("vec%0d_buserr", i), 32'(e), 32'(vec[i].exp_err));
      chk($sformatf("vec%0d_exc", i), 32'(x), 32'(vec[i].exp_exc));
`endif
    end

    // keypad fill with overflow, then drain
    for (int i = 1; i <= 5; i++) push_key(4'(i));
    read_chk("kstat_full_ovf", A_KSTA, 32'h34);
    for (int i = 1; i <= 4; i++) read_chk("kdata_pop", A_KDAT, 32'(i));
    read_chk("kdata_empty", A_KDAT, 32'h0);
    read_chk("kstat_cleared", A_KSTA, 32'h0);

    // key strobes coinciding with the ACCESS edge of status/data reads
    for (int i = 1; i <= 4; i++) push_key(4'(i));
    read_inj("kstat_drop_same", A_KSTA, 4'd9, 32'h14);
    read_chk("kdata_after_drop", A_KDAT, 32'h1);
    read_inj("kstat_push_same", A_KSTA, 4'd6, 32'h23);
    read_chk("kstat_ovf_clear_wins", A_KSTA, 32'h14);
    read_inj("kdata_push_pop_full", A_KDAT, 4'd7, 32'h2);
    read_chk("kstat_count_same", A_KSTA, 32'h14);
    read_chk("kdrain0", A_KDAT, 32'h3);
    read_chk("kdrain1", A_KDAT, 32'h4);
    read_chk("kdrain2", A_KDAT, 32'h6);
    read_chk("kdrain3", A_KDAT, 32'h7);
    read_chk("kstat_drained", A_KSTA, 32'h0);

    // lock holds off a pending request
    @(negedge clk);
    lock = 1'b1; req = 1'b1; we_r = 1'b0; addr_r = A_LED;
    saw = 1'b0;
    repeat (10) begin @(posedge clk); #1; if (ready) saw = 1'b1; end
    chk("lock_blocks", 32'(saw), 32'd0);
    @(negedge clk);
    lock = 1'b0;
    n = 0;
    while (!ready && n < 8) begin @(posedge clk); #1; n++; end
    chk("unlock_latency", 32'(n), 32'd2);
    chk("unlock_rdata", rdata, 32'h00123456);
    req = 1'b0;
    @(posedge clk); #1;

    // lock raised during ACCESS does not stall the transaction
    sw = 24'h00BEEF;
    @(negedge clk);
    req = 1'b1; we_r = 1'b0; addr_r = A_SW;
    @(posedge clk); #1;
    lock = 1'b1;
    @(posedge clk); #1;
    chk("lock_in_access_ready", 32'(ready), 32'd1);
    chk("lock_in_access_rdata", rdata, 32'h0000BEEF);
    req = 1'b0;
    @(posedge clk); #1;
    lock = 1'b0;

    // reset during ACCESS of an LED write
    push_key(4'd5);
    @(negedge clk);
    req = 1'b1; we_r = 1'b1; addr_r = A_LED; wdata_r = 32'h00555555;
    @(posedge clk); #1;
    reset = 1'b1; req = 1'b0;
    saw = 1'b0;
    @(posedge clk); #1;
    if (ready) saw = 1'b1;
    reset = 1'b0;
    repeat (4) begin @(posedge clk); #1; if (ready) saw = 1'b1; end
    chk("reset_no_ready", 32'(saw), 32'd0);
    chk("reset_led", 32'(led), 32'd0);
    chk("reset_rdata", rdata, 32'd0);
    read_chk("reset_fifo_empty", A_KSTA, 32'h0);

    // random traffic against the reference model
    led_m = '0; ovf_m = 1'b0; q_m.delete();
    for (int it = 0; it < 200; it++) begin
      op = $urandom_range(0, 6);
      case (op)
        0: begin
          k = 4'($urandom);
          push_key(k);
          if (q_m.size() < DEPTH) q_m.push_back(int'(k));
          else ovf_m = 1'b1;
        end
        1: begin
          wd = $urandom;
          do_access(1'b1, A_LED, wd, 1'b0, 4'd0, rd, e, x);
          led_m = wd[23:0];
          chk("rnd_led_wr", 32'(led), 32'(led_m));
        end
        2: read_chk("rnd_led_rd", A_LED, {8'd0, led_m});
        3: begin
          sw = 24'($urandom);
          read_chk("rnd_sw_rd", A_SW, {8'd0, sw});
        end
        4: begin
          ex = (q_m.size() > 0) ? 32'(q_m.pop_front()) : 32'd0;
          read_chk("rnd_kdata", A_KDAT, ex);
        end
        5: begin
          ex = stat_m();
          ovf_m = 1'b0;
          read_chk("rnd_kstat", A_KSTA, ex);
        end
        default: begin
          a = $urandom;
          if (a[31:10] == 22'h3FFFFF) a[1:0] = 2'b01;
          if ($urandom_range(0, 1) == 1) begin
            do_access(1'b1, a, $urandom, 1'b0, 4'd0, rd, e, x);
            chk("rnd_unmapped_wr_led", 32'(led), 32'(led_m));
          end else begin
            do_access(1'b0, a, 32'd0, 1'b0, 4'd0, rd, e, x);
            chk("rnd_unmapped_rd", rd, 32'd0);
          end
`ifdef IO_BUSERR_EN
          chk("rnd_unmapped_buserr", 32'(e), 32'd1);
`endif
        end
      endcase
    end
    read_chk("rnd_final_kstat", A_KSTA, stat_m());

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
